// File: rtl/vga_pkg.sv
// Shared timing constants and types for the 640x480@60 scan generator.
package vga_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FP      = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BP      = 48;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FP      = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 33;
  localparam int unsigned SCENE_W   = 320;
  localparam int unsigned ADDR_W    = 17;

  localparam int unsigned H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  typedef logic [9:0]  coord_t;
  typedef logic [16:0] scene_addr_t;

endpackage

// File: rtl/vga_timing.sv
// Free-running horizontal/vertical counters with raw (unaligned) sync and visible flags.
module vga_timing import vga_pkg::*; #(
  parameter int unsigned HVisible = H_VISIBLE,
  parameter int unsigned HFp      = H_FP,
  parameter int unsigned HSync    = H_SYNC,
  parameter int unsigned HBp      = H_BP,
  parameter int unsigned VVisible = V_VISIBLE,
  parameter int unsigned VFp      = V_FP,
  parameter int unsigned VSync    = V_SYNC,
  parameter int unsigned VBp      = V_BP
) (
  input  logic       vga_clk_i,
  input  logic       rst_ni,
  output logic [9:0] h_o,
  output logic [9:0] v_o,
  output logic       visible_o,
  output logic       line_end_o,
  output logic       frame_end_o,
  output logic       hs_raw_o,
  output logic       vs_raw_o
);

  localparam coord_t HLast      = coord_t'(HVisible + HFp + HSync + HBp - 1);
  localparam coord_t VLast      = coord_t'(VVisible + VFp + VSync + VBp - 1);
  localparam coord_t HVis       = coord_t'(HVisible);
  localparam coord_t VVis       = coord_t'(VVisible);
  localparam coord_t HSyncStart = coord_t'(HVisible + HFp);
  localparam coord_t HSyncEnd   = coord_t'(HVisible + HFp + HSync);
  localparam coord_t VSyncStart = coord_t'(VVisible + VFp);
  localparam coord_t VSyncEnd   = coord_t'(VVisible + VFp + VSync);

  coord_t h_q, h_d;
  coord_t v_q, v_d;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == HLast) begin
      h_d = '0;
      v_d = (v_q == VLast) ? '0 : v_q + 10'd1;
    end
  end

  always_ff @(posedge vga_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o         = h_q;
  assign v_o         = v_q;
  assign visible_o   = (h_q < HVis) && (v_q < VVis);
  assign line_end_o  = (h_q == HLast);
  assign frame_end_o = (h_q == HLast) && (v_q == VLast);
  assign hs_raw_o    = !((h_q >= HSyncStart) && (h_q < HSyncEnd));
  assign vs_raw_o    = !((v_q >= VSyncStart) && (v_q < VSyncEnd));

endmodule

// File: rtl/scene_scan_gen.sv
// VGA scan generator producing per-pixel scene ROM addresses (2x scaled) and
// sync outputs delayed one extra cycle to match the renderer's registered RGB.
module scene_scan_gen import vga_pkg::*; #(
  parameter int unsigned HVisible = H_VISIBLE,
  parameter int unsigned HFp      = H_FP,
  parameter int unsigned HSync    = H_SYNC,
  parameter int unsigned HBp      = H_BP,
  parameter int unsigned VVisible = V_VISIBLE,
  parameter int unsigned VFp      = V_FP,
  parameter int unsigned VSync    = V_SYNC,
  parameter int unsigned VBp      = V_BP,
  parameter int unsigned SceneW   = SCENE_W
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  output logic              hs,
  output logic              vs,
  output logic              blank,
  output logic [9:0]        draw_x,
  output logic [9:0]        draw_y,
  output logic [ADDR_W-1:0] rom_address,
  output logic              frame_start
);

  localparam coord_t      VVis   = coord_t'(VVisible);
  localparam scene_addr_t Stride = scene_addr_t'(SceneW);

  coord_t h, v;
  logic   visible, line_end, frame_end, hs_raw, vs_raw;

  vga_timing #(
    .HVisible (HVisible),
    .HFp      (HFp),
    .HSync    (HSync),
    .HBp      (HBp),
    .VVisible (VVisible),
    .VFp      (VFp),
    .VSync    (VSync),
    .VBp      (VBp)
  ) u_timing (
    .vga_clk_i   (vga_clk),
    .rst_ni      (reset_n),
    .h_o         (h),
    .v_o         (v),
    .visible_o   (visible),
    .line_end_o  (line_end),
    .frame_end_o (frame_end),
    .hs_raw_o    (hs_raw),
    .vs_raw_o    (vs_raw)
  );

  scene_addr_t line_base_q, line_base_d;
  scene_addr_t rom_address_q, rom_address_d;
  coord_t      draw_x_q, draw_x_d, draw_y_q, draw_y_d;
  logic        blank_q, blank_d, frame_start_q, frame_start_d;
  logic        hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d;
  logic        hs_q, hs_d, vs_q, vs_d;

  always_comb begin
    line_base_d = line_base_q;
    // Each scene row covers two display lines, so advance after every odd visible line.
    if (frame_end) begin
      line_base_d = '0;
    end else if (line_end && v[0] && (v < VVis)) begin
      line_base_d = line_base_q + Stride;
    end

    rom_address_d = visible ? (line_base_q + scene_addr_t'(h[9:1])) : '0;
    draw_x_d      = h;
    draw_y_d      = v;
    blank_d       = visible;
    frame_start_d = (h == '0) && (v == '0);
    hs_pipe_d     = hs_raw;
    vs_pipe_d     = vs_raw;
    hs_d          = hs_pipe_q;
    vs_d          = vs_pipe_q;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      line_base_q   <= '0;
      rom_address_q <= '0;
      draw_x_q      <= '0;
      draw_y_q      <= '0;
      blank_q       <= 1'b0;
      frame_start_q <= 1'b0;
      hs_pipe_q     <= 1'b1;
      vs_pipe_q     <= 1'b1;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
    end else begin
      line_base_q   <= line_base_d;
      rom_address_q <= rom_address_d;
      draw_x_q      <= draw_x_d;
      draw_y_q      <= draw_y_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign draw_x      = draw_x_q;
  assign draw_y      = draw_y_q;
  assign rom_address = rom_address_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_scene_scan_gen.sv
// Bench for scene_scan_gen: full-size instance plus a shrunken-timing instance so whole
// frames fit in a short run; both compared every cycle against a pixel-index model.
module tb_scene_scan_gen;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        blank;
    logic [16:0] addr;
    logic        fs;
    logic        hs;
    logic        vs;
  } obs_t;

  typedef struct {
    int ht; int hv; int hs0; int hsw;
    int vt; int vv; int vs0; int vsw;
    int sw;
  } cfg_t;

  typedef struct {
    int x; int y; bit blank; int addr; bit fs;
  } vec_t;

  localparam cfg_t CDef   = '{ht: 800, hv: 640, hs0: 656, hsw: 96,
                              vt: 525, vv: 480, vs0: 490, vsw: 2, sw: 320};
  localparam cfg_t CSmall = '{ht: 24, hv: 16, hs0: 18, hsw: 3,
                              vt: 19, vv: 12, vs0: 14, vsw: 2, sw: 8};

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  bit   sb_en = 1'b0;
  int   t;
  int   vectors = 0;
  int   errs = 0;

  logic        d_hs, d_vs, d_blank, d_fs;
  logic [9:0]  d_x, d_y;
  logic [16:0] d_addr;
  logic        s_hs, s_vs, s_blank, s_fs;
  logic [9:0]  s_x, s_y;
  logic [16:0] s_addr;
  obs_t        d_obs, s_obs;

  assign d_obs = {d_x, d_y, d_blank, d_addr, d_fs, d_hs, d_vs};
  assign s_obs = {s_x, s_y, s_blank, s_addr, s_fs, s_hs, s_vs};

  always #5 clk = ~clk;

  scene_scan_gen u_dut (
    .vga_clk     (clk),
    .reset_n     (reset_n),
    .hs          (d_hs),
    .vs          (d_vs),
    .blank       (d_blank),
    .draw_x      (d_x),
    .draw_y      (d_y),
    .rom_address (d_addr),
    .frame_start (d_fs)
  );

  scene_scan_gen #(
    .HVisible (16), .HFp (2), .HSync (3), .HBp (3),
    .VVisible (12), .VFp (2), .VSync (2), .VBp (3),
    .SceneW   (8)
  ) u_small (
    .vga_clk     (clk),
    .reset_n     (reset_n),
    .hs          (s_hs),
    .vs          (s_vs),
    .blank       (s_blank),
    .draw_x      (s_x),
    .draw_y      (s_y),
    .rom_address (s_addr),
    .frame_start (s_fs)
  );

  // Clock edges seen since reset release; pixel index shown at the outputs is t-1.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) t <= 0;
    else          t <= t + 1;
  end

  function automatic obs_t model(int n, cfg_t c);
    obs_t o;
    int h, v, hp, vp;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    if (n < 0) return o;
    h = n % c.ht;
    v = (n / c.ht) % c.vt;
    o.x = 10'(h);
    o.y = 10'(v);
    o.blank = (h < c.hv) && (v < c.vv);
    o.addr = o.blank ? 17'((v / 2) * c.sw + h / 2) : 17'd0;
    o.fs = (h == 0) && (v == 0);
    if (n > 0) begin
      hp = (n - 1) % c.ht;
      vp = ((n - 1) / c.ht) % c.vt;
      o.hs = !(hp >= c.hs0 && hp < c.hs0 + c.hsw);
      o.vs = !(vp >= c.vs0 && vp < c.vs0 + c.vsw);
    end
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("x=%0d y=%0d blank=%0b addr=%0d fs=%0b hs=%0b vs=%0b",
                     o.x, o.y, o.blank, o.addr, o.fs, o.hs, o.vs);
  endfunction

  task automatic check_obs(string name, obs_t act, obs_t exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @%0t: got %s, expected %s", name, $time, fmt(act), fmt(exp));
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_en) begin
      check_obs("scoreboard_default", d_obs, model(t - 1, CDef));
      check_obs("scoreboard_small", s_obs, model(t - 1, CSmall));
    end
  end

  task automatic wait_pix(input int x, input int y, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (int'(d_x) == x && int'(d_y) == y) begin
        ok = 1'b1;
        return;
      end
    end
    vectors++;
    errs++;
    $display("FAIL wait_pix: (%0d,%0d) not reached, got x=%0d y=%0d", x, y, d_x, d_y);
  endtask

  vec_t tbl[12];

  initial begin
    bit ok;
    int low, first_x, cnt, vlow, vfx, vfy;

    tbl[0]  = '{x: 0,   y: 0,  blank: 1, addr: 0,    fs: 1};
    tbl[1]  = '{x: 638, y: 0,  blank: 1, addr: 319,  fs: 0};
    tbl[2]  = '{x: 639, y: 0,  blank: 1, addr: 319,  fs: 0};
    tbl[3]  = '{x: 640, y: 0,  blank: 0, addr: 0,    fs: 0};
    tbl[4]  = '{x: 0,   y: 1,  blank: 1, addr: 0,    fs: 0};
    tbl[5]  = '{x: 0,   y: 2,  blank: 1, addr: 320,  fs: 0};
    tbl[6]  = '{x: 5,   y: 2,  blank: 1, addr: 322,  fs: 0};
    tbl[7]  = '{x: 799, y: 2,  blank: 0, addr: 0,    fs: 0};
    tbl[8]  = '{x: 0,   y: 3,  blank: 1, addr: 320,  fs: 0};
    tbl[9]  = '{x: 0,   y: 4,  blank: 1, addr: 640,  fs: 0};
    tbl[10] = '{x: 641, y: 10, blank: 0, addr: 0,    fs: 0};
    tbl[11] = '{x: 639, y: 11, blank: 1, addr: 1919, fs: 0};

    #1 reset_n = 1'b0;
    #1 sb_en = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      wait_pix(tbl[i].x, tbl[i].y, ok);
      if (ok) begin
        check_int($sformatf("tbl%0d_blank", i), int'(d_blank), int'(tbl[i].blank));
        check_int($sformatf("tbl%0d_addr", i), int'(d_addr), tbl[i].addr);
        check_int($sformatf("tbl%0d_fs", i), int'(d_fs), int'(tbl[i].fs));
        if (i == 0) begin
          check_int("first_hs", int'(d_hs), 1);
          check_int("first_vs", int'(d_vs), 1);
        end
      end
    end

    // hsync width and alignment on one full line
    wait_pix(0, 12, ok);
    low = 0;
    first_x = -1;
    repeat (800) begin
      @(negedge clk);
      if (!d_hs) begin
        low++;
        if (first_x < 0) first_x = int'(d_x);
      end
    end
    check_int("hs_low_cycles", low, 96);
    check_int("hs_first_low_x", first_x, 657);

    // Whole-frame period and vsync on the shrunken instance
    cnt = 0;
    for (int i = 0; i < 1000 && !s_fs; i++) @(negedge clk);
    check_int("small_fs_seen", int'(s_fs), 1);
    vlow = 0;
    vfx = -1;
    vfy = -1;
    do begin
      @(negedge clk);
      cnt++;
      if (!s_vs) begin
        vlow++;
        if (vfx < 0) begin
          vfx = int'(s_x);
          vfy = int'(s_y);
        end
      end
    end while (!s_fs && cnt < 1000);
    check_int("small_frame_period", cnt, 456);
    check_int("small_vs_low_cycles", vlow, 48);
    check_int("small_vs_first_x", vfx, 1);
    check_int("small_vs_first_y", vfy, 14);

    // Asynchronous reset mid-frame
    wait_pix(300, 15, ok);
    #2 reset_n = 1'b0;
    #1 check_obs("async_reset_default", d_obs, model(-1, CDef));
    check_obs("async_reset_small", s_obs, model(-1, CSmall));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_int("restart_x", int'(d_x), 0);
    check_int("restart_y", int'(d_y), 0);
    check_int("restart_addr", int'(d_addr), 0);
    check_int("restart_fs", int'(d_fs), 1);
    wait_pix(0, 2, ok);
    if (ok) check_int("restart_line2_addr", int'(d_addr), 320);

    repeat (2) @(negedge clk);
    sb_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/scene_scan_gen.md
Name: scene_scan_gen

Overview:
- VGA 640x480@60 timing generator plus scene ROM address generator.
- Drives the scene renderer directly with rom_address and blank (1 = visible pixel), and drives the monitor with hs/vs.
- The 320x240 scene image is scaled 2x in both axes.
- rom_address is computed incrementally with no multiplier. Sync outputs are delayed one cycle to line up with the renderer's registered RGB.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_VISIBLE, 480, active lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- SCENE_W, 320, scene row stride in ROM words
- ADDR_W, 17, ROM address width

Ports:
- vga_clk  in  1  pixel clock (25 MHz)
- reset_n  in  1  asynchronous active-low reset
- hs  out  1  horizontal sync, active low, delayed one cycle vs blank
- vs  out  1  vertical sync, active low, delayed one cycle vs blank
- blank  out  1  1 = current pixel visible (h<640 && v<480)
- draw_x  out  10  current pixel column
- draw_y  out  10  current pixel row
- rom_address  out  ADDR_W  scene ROM word address for current pixel
- frame_start  out  1  one-cycle pulse with pixel (0,0)

Behaviour:
- Clock and reset: one clock, vga_clk. Reset is asynchronous and active-low on reset_n.
- Internal counters:
  - h_cnt runs 0..799 and wraps.
  - v_cnt runs 0..524 and advances when h_cnt wraps.
  - Both are 10 bits.
- Timing: the line period is 800 cycles. The frame period is 525 lines = 420000 cycles.
- Reset values:
  - Counters 0.
  - draw_x=0, draw_y=0, rom_address=0, blank=0, frame_start=0.
  - hs=1, vs=1.
- Output registers:
  - draw_x, draw_y, blank, rom_address and frame_start are registered from counter state; all describe the same pixel P(t).
  - First posedge after reset_n rises: outputs describe (0,0). blank=1, rom_address=0, frame_start=1.
- Sync generation:
  - hs_raw = 0 iff 656 <= h < 752.
  - vs_raw = 0 iff 490 <= v < 492.
  - hs and vs are hs_raw/vs_raw of P(t) registered once more, so they describe P(t-1), aligned with scene RGB.
- Address generation (no multiply):
  - A line_base register holds v/2 * SCENE_W.
  - Cleared at end of line 524 (frame wrap).
  - At the end of each odd visible line (v odd, v<=479), line_base += SCENE_W.
  - In the visible region: rom_address = line_base + (h>>1).
  - Outside the visible region: rom_address = 0.
  - All arithmetic is unsigned ADDR_W bits. The maximum value is 76799, so there is no overflow.
- draw_x and draw_y track counters in blanking too: 640..799 and 480..524.
- Simultaneous events: at (799,524), h wraps, v wraps and line_base clears in the same cycle. The next pixel is (0,0) with address 0.
- Reset mid-frame: all state returns to the reset values immediately (asynchronous). Scanning restarts at (0,0) on the first edge after release. No partial line is emitted.
- No stall or enable input; the block is free-running.

Decomposition:
- Package vga_pkg:
  - Timing localparams: H_TOTAL=800, V_TOTAL=525, sync start/end derived from the parameters.
  - typedef logic [9:0] coord_t.
  - typedef logic [16:0] scene_addr_t.
- Natural sub-module: vga_timing (counters, hs_raw/vs_raw, visible flag).
- scene_scan_gen wraps vga_timing, and adds the line_base/address logic and the output/sync-delay registers.

Test Plan:
- Reset release: hold reset_n=0 for 5 cycles, release. First edge: draw_x=0, draw_y=0, blank=1, rom_address=0, frame_start=1, hs=1, vs=1.
- Line 0 addresses: at draw_x=638 and 639, rom_address=319 both times. At draw_x=640, blank=0 and rom_address=0.
- Scaling: line 1 column 0 -> addr 0. Line 2 column 0 -> addr 320. Line 2 column 5 -> addr 322. Line 479 column 639 -> addr 76799.
- Sync:
  - hs low for exactly 96 cycles per line, first low cycle when draw_x=657 (one cycle after h=656).
  - vs low for 1600 cycles, starting at the cycle after (0,490).
  - Frame period 420000 cycles between frame_start pulses.
- Reset mid-frame: assert reset_n=0 at (300,200) -> outputs go to reset values the same cycle, without waiting for a clock edge. After release, pixel (0,0) with addr 0, and line_base restarts (line 2 column 0 gives 320).
- Full-frame scoreboard: for every pixel compare rom_address to (v/2)*320 + h/2 when visible, else 0. Check blank = (h<640 && v<480) over 2 consecutive frames.
